// File: rtl/dx_issue_stage_pkg.sv
// Shared constants for the FD->DX issue stage: zero register, FSM encoding, bubble field values.
package dx_issue_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } issue_state_t;

  localparam logic        BUB_VALID = 1'b0;
  localparam logic        BUB_CTRL  = 1'b0;
  localparam logic [4:0]  BUB_REG   = 5'd0;
  localparam logic [31:0] BUB_PC    = 32'd0;

endpackage

// File: rtl/dx_issue_stage_hazard.sv
// Combinational load-use and intra-pair hazard detection for both FD slots against DX.
module issue_hazard_check
  import dx_issue_stage_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_dx_m2r_1,
  input  logic [REG_AW-1:0] i_dx_rd_1,
  input  logic              i_dx_m2r_2,
  input  logic [REG_AW-1:0] i_dx_rd_2,
  input  logic              i_valid_1,
  input  logic              i_valid_2,
  input  logic [REG_AW-1:0] i_rs_1,
  input  logic [REG_AW-1:0] i_rt_1,
  input  logic [REG_AW-1:0] i_rd_1,
  input  logic [REG_AW-1:0] i_rs_2,
  input  logic [REG_AW-1:0] i_rt_2,
  input  logic              i_regwrite_1,
  input  logic              i_memwrite_1,
  input  logic              i_memwrite_2,
  input  logic              i_m2r_1,
  input  logic              i_m2r_2,
  input  logic              i_ctrlflow_1,
  output logic              o_lu_pair,
  output logic              o_lu_slot2,
  output logic              o_ip
);

  localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(REG_ZERO);

  logic w_ld_1;
  logic w_ld_2;
  logic w_lu_1;
  logic w_lu_2;
  logic w_raw;
  logic w_mem_mem;

  // A load in either pipe blocks any consumer; loads to r0 never do.
  assign w_ld_1 = i_dx_m2r_1 && (i_dx_rd_1 != ZERO_RD);
  assign w_ld_2 = i_dx_m2r_2 && (i_dx_rd_2 != ZERO_RD);

  assign w_lu_1 = (w_ld_1 && ((i_dx_rd_1 == i_rs_1) || (i_dx_rd_1 == i_rt_1))) ||
                  (w_ld_2 && ((i_dx_rd_2 == i_rs_1) || (i_dx_rd_2 == i_rt_1)));
  assign w_lu_2 = (w_ld_1 && ((i_dx_rd_1 == i_rs_2) || (i_dx_rd_1 == i_rt_2))) ||
                  (w_ld_2 && ((i_dx_rd_2 == i_rs_2) || (i_dx_rd_2 == i_rt_2)));

  assign w_raw     = i_regwrite_1 && (i_rd_1 != ZERO_RD) &&
                     ((i_rd_1 == i_rs_2) || (i_rd_1 == i_rt_2));
  assign w_mem_mem = (i_m2r_1 || i_memwrite_1) && (i_m2r_2 || i_memwrite_2);

  assign o_lu_pair  = (i_valid_1 && w_lu_1) || (i_valid_2 && w_lu_2);
  assign o_lu_slot2 = w_lu_2;
  assign o_ip       = i_valid_1 && i_valid_2 && (w_raw || w_mem_mem || i_ctrlflow_1);

endmodule

// File: rtl/dx_issue_stage.sv
// Dual-issue FD->DX stage: issues a pair together, split over two cycles, or as bubbles; 1-cycle latency.
// fd_stall holds PC/FD while a split or load-use stall is in progress; flush kills DX.
module dx_issue_stage
  import dx_issue_stage_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              fd_valid_1,
  input  logic              fd_valid_2,
  input  logic [PC_W-1:0]   fd_pc_1,
  input  logic [PC_W-1:0]   fd_pc_2,
  input  logic [REG_AW-1:0] fd_rs_1,
  input  logic [REG_AW-1:0] fd_rt_1,
  input  logic [REG_AW-1:0] fd_rd_1,
  input  logic [REG_AW-1:0] fd_rs_2,
  input  logic [REG_AW-1:0] fd_rt_2,
  input  logic [REG_AW-1:0] fd_rd_2,
  input  logic              fd_regWrite_1,
  input  logic              fd_memWrite_1,
  input  logic              fd_MemToReg_1,
  input  logic              fd_ctrlFlow_1,
  input  logic              fd_regWrite_2,
  input  logic              fd_memWrite_2,
  input  logic              fd_MemToReg_2,
  input  logic              fd_ctrlFlow_2,
  output logic              DX_valid_1,
  output logic [PC_W-1:0]   DX_pc_1,
  output logic [REG_AW-1:0] DX_rs_1,
  output logic [REG_AW-1:0] DX_rt_1,
  output logic [REG_AW-1:0] DX_rd_1,
  output logic              DX_regWrite_1,
  output logic              DX_memWrite_1,
  output logic              DX_MemToReg_1,
  output logic              DX_ctrlFlow_1,
  output logic              DX_valid_2,
  output logic [PC_W-1:0]   DX_pc_2,
  output logic [REG_AW-1:0] DX_rs_2,
  output logic [REG_AW-1:0] DX_rt_2,
  output logic [REG_AW-1:0] DX_rd_2,
  output logic              DX_regWrite_2,
  output logic              DX_memWrite_2,
  output logic              DX_MemToReg_2,
  output logic              DX_ctrlFlow_2,
  output logic              fd_stall,
  output logic              split_state
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              regWrite;
    logic              memWrite;
    logic              MemToReg;
    logic              ctrlFlow;
  } dx_slot_t;

  issue_state_t r_state;
  issue_state_t w_state_nxt;
  dx_slot_t     r_dx_1;
  dx_slot_t     r_dx_2;
  dx_slot_t     w_nxt_1;
  dx_slot_t     w_nxt_2;
  dx_slot_t     w_slot_1;
  dx_slot_t     w_slot_2;
  dx_slot_t     w_bubble;
  dx_slot_t     w_cand_1;
  dx_slot_t     w_cand_2;
  logic         w_stall;
  logic         w_lu_pair;
  logic         w_lu_slot2;
  logic         w_ip;

  always_comb begin
    w_bubble.valid    = BUB_VALID;
    w_bubble.pc       = PC_W'(BUB_PC);
    w_bubble.rs       = REG_AW'(BUB_REG);
    w_bubble.rt       = REG_AW'(BUB_REG);
    w_bubble.rd       = REG_AW'(BUB_REG);
    w_bubble.regWrite = BUB_CTRL;
    w_bubble.memWrite = BUB_CTRL;
    w_bubble.MemToReg = BUB_CTRL;
    w_bubble.ctrlFlow = BUB_CTRL;
  end

  assign w_slot_1 = '{valid: fd_valid_1, pc: fd_pc_1, rs: fd_rs_1, rt: fd_rt_1, rd: fd_rd_1,
                      regWrite: fd_regWrite_1, memWrite: fd_memWrite_1,
                      MemToReg: fd_MemToReg_1, ctrlFlow: fd_ctrlFlow_1};
  assign w_slot_2 = '{valid: fd_valid_2, pc: fd_pc_2, rs: fd_rs_2, rt: fd_rt_2, rd: fd_rd_2,
                      regWrite: fd_regWrite_2, memWrite: fd_memWrite_2,
                      MemToReg: fd_MemToReg_2, ctrlFlow: fd_ctrlFlow_2};

  // Invalid slots enter DX as clean bubbles so stale fields never reach bypass.
  assign w_cand_1 = fd_valid_1 ? w_slot_1 : w_bubble;
  assign w_cand_2 = fd_valid_2 ? w_slot_2 : w_bubble;

  issue_hazard_check #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .i_dx_m2r_1   (r_dx_1.MemToReg),
    .i_dx_rd_1    (r_dx_1.rd),
    .i_dx_m2r_2   (r_dx_2.MemToReg),
    .i_dx_rd_2    (r_dx_2.rd),
    .i_valid_1    (fd_valid_1),
    .i_valid_2    (fd_valid_2),
    .i_rs_1       (fd_rs_1),
    .i_rt_1       (fd_rt_1),
    .i_rd_1       (fd_rd_1),
    .i_rs_2       (fd_rs_2),
    .i_rt_2       (fd_rt_2),
    .i_regwrite_1 (fd_regWrite_1),
    .i_memwrite_1 (fd_memWrite_1),
    .i_memwrite_2 (fd_memWrite_2),
    .i_m2r_1      (fd_MemToReg_1),
    .i_m2r_2      (fd_MemToReg_2),
    .i_ctrlflow_1 (fd_ctrlFlow_1),
    .o_lu_pair    (w_lu_pair),
    .o_lu_slot2   (w_lu_slot2),
    .o_ip         (w_ip)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_nxt_1     = w_bubble;
    w_nxt_2     = w_bubble;
    w_stall     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_PAIR;
    end else if (r_state == ST_PAIR) begin
      if (w_lu_pair) begin
        w_stall = 1'b1;
      end else if (w_ip) begin
        w_nxt_1     = w_cand_1;
        w_stall     = 1'b1;
        w_state_nxt = ST_SPLIT;
      end else begin
        w_nxt_1 = w_cand_1;
        w_nxt_2 = w_cand_2;
      end
    end else begin
      // Slot 1 already sits in DX_1; a load there feeding slot 2 shows up as LU here.
      if (w_lu_slot2) begin
        w_stall = 1'b1;
      end else begin
        w_nxt_2     = w_cand_2;
        w_state_nxt = ST_PAIR;
      end
    end
  end

  // Reset value '0 is the bubble encoding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_PAIR;
      r_dx_1  <= '0;
      r_dx_2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dx_1  <= w_nxt_1;
      r_dx_2  <= w_nxt_2;
    end
  end

  assign fd_stall    = w_stall;
  assign split_state = (r_state == ST_SPLIT);

  assign DX_valid_1    = r_dx_1.valid;
  assign DX_pc_1       = r_dx_1.pc;
  assign DX_rs_1       = r_dx_1.rs;
  assign DX_rt_1       = r_dx_1.rt;
  assign DX_rd_1       = r_dx_1.rd;
  assign DX_regWrite_1 = r_dx_1.regWrite;
  assign DX_memWrite_1 = r_dx_1.memWrite;
  assign DX_MemToReg_1 = r_dx_1.MemToReg;
  assign DX_ctrlFlow_1 = r_dx_1.ctrlFlow;
  assign DX_valid_2    = r_dx_2.valid;
  assign DX_pc_2       = r_dx_2.pc;
  assign DX_rs_2       = r_dx_2.rs;
  assign DX_rt_2       = r_dx_2.rt;
  assign DX_rd_2       = r_dx_2.rd;
  assign DX_regWrite_2 = r_dx_2.regWrite;
  assign DX_memWrite_2 = r_dx_2.memWrite;
  assign DX_MemToReg_2 = r_dx_2.MemToReg;
  assign DX_ctrlFlow_2 = r_dx_2.ctrlFlow;

endmodule

// File: doc/dx_issue_stage.md
Name: dx_issue_stage

Overview:
- Dual-issue FD->DX issue stage and DX pipeline latch of the 2-wide processor.
- Sits directly upstream of the bypass unit and produces the DX_rs/DX_rt/DX_rd and control fields that the bypass unit consumes.
- Decides each cycle whether the fetched pair issues together, issues split over two cycles, or issues as a bubble.

Parameters:
- REG_AW, 5, register-specifier width.
- PC_W, 32, PC width.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  taken branch/jr/bex resolved in X; kills the DX contents.
- fd_valid_1, fd_valid_2  in  1 each  FD slot valid.
- fd_pc_1, fd_pc_2  in  PC_W each  FD slot PC.
- fd_rs_1, fd_rt_1, fd_rd_1, fd_rs_2, fd_rt_2, fd_rd_2  in  REG_AW each  decoded specifiers.
- fd_regWrite_x, fd_memWrite_x, fd_MemToReg_x, fd_ctrlFlow_x  in  1 each (x=1,2)  decoded controls.
- DX_valid_x, DX_pc_x, DX_rs_x, DX_rt_x, DX_rd_x, DX_regWrite_x, DX_memWrite_x, DX_MemToReg_x, DX_ctrlFlow_x  out  registered, same widths as the fd_ inputs.
- fd_stall  out  1  combinational; holds PC/FD latch this cycle.
- split_state  out  1  registered; 1 = second half of a split pair.

Behaviour:
- Reset (async, reset_n=0): every DX_ output=0 (bubble), split_state=0, so fd_stall=0. Outputs stay at these values until the first rising clock edge after release.
- Bubble definition: valid, regWrite, memWrite, MemToReg, ctrlFlow = 0; rs/rt/rd = 0; pc = 0.
- Load-use hazard (LU) on candidate slot s: some DX_y satisfies DX_MemToReg_y & DX_rd_y!=0 & (DX_rd_y==fd_rs_s | DX_rd_y==fd_rt_s).
- Intra-pair hazard (IP), checked in PAIR with both slots valid. IP is true if any of:
  - fd_regWrite_1 & fd_rd_1!=0 & (fd_rd_1==fd_rs_2 | fd_rd_1==fd_rt_2);
  - both slots are memory ops (MemToReg or memWrite);
  - fd_ctrlFlow_1.
- FSM states PAIR (0) and SPLIT (1). Priority each cycle: flush > LU > IP.
  - flush: DX_1 and DX_2 get bubbles; next state PAIR; fd_stall=0. The FD contents are discarded by the fetch logic.
  - PAIR, LU on any valid slot: both DX get bubbles; fd_stall=1; stay PAIR.
  - PAIR, IP: DX_1<=slot1, DX_2<=bubble; fd_stall=1; next SPLIT.
  - PAIR, otherwise: DX_1<=slot1 (or bubble if !fd_valid_1), DX_2<=slot2 (or bubble); fd_stall=0.
  - SPLIT, LU on slot2: both bubbles; fd_stall=1; stay SPLIT. This covers a slot1 load feeding slot2.
  - SPLIT, otherwise: DX_1<=bubble, DX_2<=slot2; fd_stall=0; next PAIR.
- Slot 2 always issues in pipe 2. Pipe identity of a producer is preserved for the bypass unit.
- fd_valid_1=0 with fd_valid_2=1 is legal: slot2 issues alone in pipe 2 with no IP check.
- Latency: one cycle FD->DX. A split pair costs exactly one extra cycle.
- rd=0 producers never create a hazard.
- flush during SPLIT aborts the held slot2.

Decomposition:
- Shared pkg constants: REG_ZERO=5'd0, ST_PAIR=1'b0, ST_SPLIT=1'b1, and the bubble field values.
- One natural sub-module, issue_hazard_check: combinational LU/IP detection. It is instantiated once and evaluates both slots.
- The FSM and DX registers live in the top module.

Test Plan:
- Reset: pulse reset_n low mid-cycle -> all DX_ outputs 0, split_state=0, fd_stall=0 asynchronously.
- Independent pair: add r3,r1,r2 / sub r6,r4,r5 -> both issued next edge, DX_rd_1=3, DX_rd_2=6, fd_stall=0.
- Intra-pair RAW: add r3,r1,r2 / add r7,r3,r4 -> cycle1 DX_rd_1=3 with DX_2 bubble, fd_stall=1; cycle2 DX_1 bubble, DX_rd_2=7, DX_rs_2=3, split_state=1 then 0.
- Load-use: DX_1 holds lw r5 (MemToReg=1) and FD has add r8,r5,r1 -> one bubble pair with fd_stall=1, then add issues.
- Split load: lw r5 / add r9,r5,r2 -> split, then one extra SPLIT bubble cycle, then add in pipe 2. Total 3 cycles.
- Flush in SPLIT: assert flush in the cycle after a split -> both DX bubbles, split_state=0, fd_stall=0.
